// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the synchronous InstructionCache address from
// next-PC and registers the returned instruction into the IF/ID pipeline register.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             br_en,
  input  logic [31:0]      br_target,
  output logic [29:0]      icache_addr,
  input  logic [31:0]      icache_data,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_inst,
  output logic             id_valid,
  output logic             id_misalign,
  output logic [CNT_W-1:0] fetch_cnt
);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic        misalign_r;
  logic        redirect_s;
  logic        f_valid_s;
  logic        if_write_s;
  logic [31:0] next_pc_s;

  // Next-PC selection; the cache samples next_pc so its data lines up with pc_r one edge later.
  always_comb begin
    redirect_s = 1'b0;
    f_valid_s  = 1'b0;
    next_pc_s  = pc_r;
    f_valid_s  = (state_r == RUN);
    redirect_s = br_en && f_valid_s;
    if (redirect_s) begin
      next_pc_s = {br_target[31:2], 2'b00};
    end else if (f_valid_s && !stall) begin
      next_pc_s = pc_r + 32'd4;
    end else begin
      next_pc_s = pc_r;
    end
  end

  assign icache_addr = next_pc_s[31:2];
  assign if_write_s  = !redirect_s && !flush && !stall;

  // PC, boot sequencing and pending-misalign flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= BOOT;
      pc_r       <= RESET_PC;
      misalign_r <= 1'b0;
    end else begin
      case (state_r)
        BOOT:    state_r <= RUN;
        RUN:     state_r <= RUN;
        default: state_r <= BOOT;
      endcase
      pc_r <= next_pc_s;
      // The flag rides with the first real instruction fetched from the redirect target.
      if (redirect_s) begin
        misalign_r <= |br_target[1:0];
      end else if (if_write_s && f_valid_s) begin
        misalign_r <= 1'b0;
      end else begin
        misalign_r <= misalign_r;
      end
    end
  end

  // IF/ID pipeline register and delivered-instruction counter; redirect beats a decode stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_pc       <= 32'h0000_0000;
      id_inst     <= NOP_INST;
      id_valid    <= 1'b0;
      id_misalign <= 1'b0;
      fetch_cnt   <= {CNT_W{1'b0}};
    end else if (redirect_s || flush) begin
      id_pc       <= pc_r;
      id_inst     <= NOP_INST;
      id_valid    <= 1'b0;
      id_misalign <= 1'b0;
      fetch_cnt   <= fetch_cnt;
    end else if (stall) begin
      id_pc       <= id_pc;
      id_inst     <= id_inst;
      id_valid    <= id_valid;
      id_misalign <= id_misalign;
      fetch_cnt   <= fetch_cnt;
    end else begin
      id_pc       <= pc_r;
      id_inst     <= icache_data;
      id_valid    <= f_valid_s;
      id_misalign <= misalign_r && f_valid_s;
      if (f_valid_s) begin
        fetch_cnt <= fetch_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        fetch_cnt <= fetch_cnt;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: synchronous cache model, per-edge vector table
// with an expected-result queue, and a hand-written asynchronous reset sequence.
module tb_inst_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        br_en = 1'b0;
  logic [31:0] br_target = 32'h0000_0000;
  logic [29:0] icache_addr;
  logic [31:0] icache_data = 32'h0000_0000;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        id_misalign;
  logic [31:0] fetch_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        stall;
    logic        flush;
    logic        br_en;
    logic [31:0] tgt;
    logic [29:0] exp_addr;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic        exp_valid;
    logic        exp_mis;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t tbl[20];
  vec_t sb_q[$];

  inst_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .br_en(br_en),
    .br_target(br_target), .icache_addr(icache_addr), .icache_data(icache_data),
    .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid), .id_misalign(id_misalign),
    .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  // Program image: first 64 words populated, everything beyond reads as zero.
  function automatic logic [31:0] img(input logic [29:0] w);
    if (w == 30'd0) return 32'h0000_0193;
    if (w == 30'd1) return 32'h00f0_0093;
    if (w < 30'd64) return 32'h1000_0000 | {2'b00, w};
    return 32'h0000_0000;
  endfunction

  always @(posedge clk) icache_data <= img(icache_addr);

  function automatic vec_t mk(input logic s, input logic f, input logic b, input logic [31:0] t,
                              input logic [29:0] a, input logic [31:0] p, input logic [31:0] i,
                              input logic v, input logic m, input logic [31:0] c);
    vec_t r;
    r.stall = s; r.flush = f; r.br_en = b; r.tgt = t; r.exp_addr = a; r.exp_pc = p;
    r.exp_inst = i; r.exp_valid = v; r.exp_mis = m; r.exp_cnt = c;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_id(input string tag, input logic [31:0] p, input logic [31:0] i,
                        input logic v, input logic m, input logic [31:0] c);
    chk({tag, ".id_pc"}, id_pc, p);
    chk({tag, ".id_inst"}, id_inst, i);
    chk({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, v});
    chk({tag, ".id_misalign"}, {31'd0, id_misalign}, {31'd0, m});
    chk({tag, ".fetch_cnt"}, fetch_cnt, c);
  endtask

  initial begin
    vec_t e;
    // stall flush br tgt | addr id_pc id_inst valid mis cnt
    tbl[0]  = mk(0, 0, 0, 32'h0,         30'h0,        32'h0,         img(30'd0),  0, 0, 32'd0);
    tbl[1]  = mk(0, 0, 0, 32'h0,         30'h1,        32'h0,         img(30'd0),  1, 0, 32'd1);
    tbl[2]  = mk(0, 0, 0, 32'h0,         30'h2,        32'h4,         img(30'd1),  1, 0, 32'd2);
    tbl[3]  = mk(1, 0, 0, 32'h0,         30'h2,        32'h4,         img(30'd1),  1, 0, 32'd2);
    tbl[4]  = mk(1, 0, 0, 32'h0,         30'h2,        32'h4,         img(30'd1),  1, 0, 32'd2);
    tbl[5]  = mk(1, 0, 0, 32'h0,         30'h2,        32'h4,         img(30'd1),  1, 0, 32'd2);
    tbl[6]  = mk(0, 0, 0, 32'h0,         30'h3,        32'h8,         img(30'd2),  1, 0, 32'd3);
    tbl[7]  = mk(0, 0, 0, 32'h0,         30'h4,        32'hC,         img(30'd3),  1, 0, 32'd4);
    tbl[8]  = mk(0, 1, 0, 32'h0,         30'h5,        32'h10,        NOP,         0, 0, 32'd4);
    tbl[9]  = mk(0, 0, 0, 32'h0,         30'h6,        32'h14,        img(30'd5),  1, 0, 32'd5);
    tbl[10] = mk(1, 0, 1, 32'h40,        30'h10,       32'h18,        NOP,         0, 0, 32'd5);
    tbl[11] = mk(0, 0, 0, 32'h0,         30'h11,       32'h40,        img(30'd16), 1, 0, 32'd6);
    tbl[12] = mk(0, 0, 1, 32'h42,        30'h10,       32'h44,        NOP,         0, 0, 32'd6);
    tbl[13] = mk(0, 0, 0, 32'h0,         30'h11,       32'h40,        img(30'd16), 1, 1, 32'd7);
    tbl[14] = mk(0, 0, 0, 32'h0,         30'h12,       32'h44,        img(30'd17), 1, 0, 32'd8);
    tbl[15] = mk(1, 1, 0, 32'h0,         30'h12,       32'h48,        NOP,         0, 0, 32'd8);
    tbl[16] = mk(0, 0, 0, 32'h0,         30'h13,       32'h48,        img(30'd18), 1, 0, 32'd9);
    tbl[17] = mk(0, 0, 1, 32'hFFFF_FFFC, 30'h3FFFFFFF, 32'h4C,        NOP,         0, 0, 32'd9);
    tbl[18] = mk(0, 0, 0, 32'h0,         30'h0,        32'hFFFF_FFFC, 32'h0,       1, 0, 32'd10);
    tbl[19] = mk(0, 0, 0, 32'h0,         30'h1,        32'h0,         img(30'd0),  1, 0, 32'd11);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.icache_addr", {2'b00, icache_addr}, 32'h0);
    chk_id("rst", 32'h0, NOP, 1'b0, 1'b0, 32'd0);
    rst_n = 1'b1;

    for (int k = 0; k < 20; k++) begin
      stall = tbl[k].stall; flush = tbl[k].flush;
      br_en = tbl[k].br_en; br_target = tbl[k].tgt;
      sb_q.push_back(tbl[k]);
      #1;
      chk($sformatf("v%0d.icache_addr", k), {2'b00, icache_addr}, {2'b00, tbl[k].exp_addr});
      @(posedge clk);
      @(negedge clk);
      e = sb_q.pop_front();
      chk_id($sformatf("v%0d", k), e.exp_pc, e.exp_inst, e.exp_valid, e.exp_mis, e.exp_cnt);
    end
    stall = 1'b0; flush = 1'b0; br_en = 1'b0; br_target = 32'h0;

    // Asynchronous reset between edges, then boot again from RESET_PC.
    #2 rst_n = 1'b0;
    #1;
    chk_id("arst", 32'h0, NOP, 1'b0, 1'b0, 32'd0);
    chk("arst.icache_addr", {2'b00, icache_addr}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("reboot.id_valid", {31'd0, id_valid}, 32'd0);
    chk("reboot.icache_addr", {2'b00, icache_addr}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    chk_id("reboot1", 32'h0, img(30'd0), 1'b1, 1'b0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk_id("reboot2", 32'h4, img(30'd1), 1'b1, 1'b0, 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
